axi_master_read: RTL and testbench

- AXI4 read-channel master bridge between a CPU load/fetch port and the bus AR/R channels.
- It sits directly upstream of the SRAM-side AXI read slave.
- It converts a held CPU read request into one AR transfer of 1..16 INCR beats.
- It collects the R beats, presents each beat to the CPU, and holds the CPU stalled until the burst completes.

---
 rtl/axi_master_read.sv | 154 +++++++++++++++
 tb/tb_axi_master_read.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_read.sv
// AXI4 read-channel master: turns a held CPU read request into one INCR burst
// on AR, collects the R beats, and stalls the CPU until the burst completes.
module axi_master_read #(
    parameter logic [3:0] MASTER_ID = 4'd0,
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [3:0]        ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [3:0]        RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ARVALID holds with stable ARADDR/ARLEN until accepted, RREADY is high
    // only in DATA, and the slave may present RVALID at any time.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_araddr;
    logic [3:0]          r_arlen;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_err;
    logic                w_arvalid;
    logic                w_rready;
    logic                w_done;
    logic                w_stall;
    logic                w_beat;
    logic                w_last_expected;
    logic                w_beat_err;

    // RLAST must coincide exactly with the ARLEN-th beat; either mismatch
    // direction (early RLAST or missing RLAST) flags the request.
    assign w_beat          = RVALID && w_rready;
    assign w_last_expected = (r_cnt == r_arlen);
    assign w_beat_err      = (RRESP != 2'b00) || (RID != MASTER_ID)
                           || (RLAST != w_last_expected);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_done    = 1'b0;
        w_stall   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = req;
                if (req) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                w_arvalid = 1'b1;
                w_stall   = 1'b1;
                if (ARREADY) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                w_rready = 1'b1;
                w_stall  = 1'b1;
                if (RVALID && RLAST) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (r_state == S_IDLE && req) begin
                r_araddr <= req_addr;
                r_arlen  <= req_len;
                r_cnt    <= '0;
                r_err    <= 1'b0;
            end
            if (w_beat) begin
                r_rd_data  <= RDATA;
                r_rd_valid <= 1'b1;
                // Saturate so overrun beats cannot wrap back onto ARLEN.
                if (r_cnt != 4'hF) begin
                    r_cnt <= r_cnt + 4'd1;
                end
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign stall     = w_stall;
    assign done      = w_done;
    assign err       = r_err;
    assign ARID      = MASTER_ID;
    assign ARADDR    = r_araddr;
    assign ARLEN     = r_arlen;
    assign ARSIZE    = 3'b010;
    assign ARBURST   = 2'b01;
    assign ARVALID   = w_arvalid;
    assign RREADY    = w_rready;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_axi_master_read.sv
// Directed bench for axi_master_read: stimulus tasks act as CPU and AXI slave,
// a monitor pops expected beats / done-time err values from queues.
module tb_axi_master_read;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        stall;
    logic        done;
    logic        err;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];

    always #5 clk = ~clk;

    axi_master_read #(.MASTER_ID(4'd0), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
        .rd_data(rd_data), .rd_valid(rd_valid), .stall(stall), .done(done), .err(err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY), .dbg_state(dbg_state)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every rd_valid pulse and every done pulse consumes one entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rd_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp  = n_cmp + 1;
                        n_fail = n_fail + 1;
                        $display("FAIL rd_valid_extra: got beat %h expected none", rd_data);
                    end else begin
                        check("rd_data", rd_data, exp_q.pop_front());
                    end
                end
                if (done) begin
                    if (exp_err_q.size() == 0) begin
                        n_cmp  = n_cmp + 1;
                        n_fail = n_fail + 1;
                        $display("FAIL done_extra: got done expected none");
                    end else begin
                        check("done_err", err, exp_err_q.pop_front());
                    end
                    check("done_stall", stall, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic run_read(input logic [31:0] addr, input logic [3:0] len,
                            input int ar_wait, input int r_delay, input int n_beats,
                            input int bubble_at, input int bad_beat,
                            input logic [1:0] bad_resp, input logic [3:0] bad_rid,
                            input logic [31:0] base, input logic exp_err);
        @(negedge clk);
        req      = 1'b1;
        req_addr = addr;
        req_len  = len;
        ARREADY  = (ar_wait == 0);
        @(negedge clk);
        check("ar_valid_rise", ARVALID, 1);
        check("ar_addr", ARADDR, addr);
        check("ar_len", ARLEN, len);
        check("ar_size", ARSIZE, 3'b010);
        check("ar_burst", ARBURST, 2'b01);
        check("ar_id", ARID, 4'd0);
        check("err_cleared", err, 0);
        check("stall_addr", stall, 1);
        check("rready_addr", RREADY, 0);
        req_addr = ~addr;
        req_len  = ~len;
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge clk);
            check("ar_valid_hold", ARVALID, 1);
            check("ar_addr_hold", ARADDR, addr);
            check("ar_len_hold", ARLEN, len);
            if (i == ar_wait - 1) ARREADY = 1'b1;
        end
        @(negedge clk);
        ARREADY = 1'b0;
        check("ar_valid_drop", ARVALID, 0);
        check("rready_data", RREADY, 1);
        check("state_data", dbg_state, 2);
        repeat (r_delay) @(negedge clk);
        check("stall_data", stall, 1);
        for (int b = 0; b < n_beats; b++) begin
            if (b == bubble_at) begin
                RVALID = 1'b0;
                @(negedge clk);
            end
            RVALID = 1'b1;
            RDATA  = base + 32'(b);
            RID    = (b == bad_beat) ? bad_rid : 4'd0;
            RRESP  = (b == bad_beat) ? bad_resp : 2'b00;
            RLAST  = (b == n_beats - 1);
            exp_q.push_back(base + 32'(b));
            if (b == n_beats - 1) exp_err_q.push_back(exp_err);
            @(negedge clk);
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
        req    = 1'b0;
        check("done_pulse", done, 1);
        check("rready_fin", RREADY, 0);
        check("state_fin", dbg_state, 3);
        @(negedge clk);
        check("state_idle", dbg_state, 0);
        check("done_once", done, 0);
        check("err_sticky", err, exp_err);
        check("stall_idle", stall, 0);
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; req_addr = '0; req_len = '0;
        ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
        #12;
        check("rst_arvalid", ARVALID, 0);
        check("rst_rready", RREADY, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_araddr", ARADDR, 0);
        check("rst_arlen", ARLEN, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_arid", ARID, 0);
        check("rst_arsize", ARSIZE, 3'b010);
        check("rst_arburst", ARBURST, 2'b01);
        check("rst_state", dbg_state, 0);
        check("rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b1;

        // single beat, ARREADY already high
        run_read(32'h0001_0010, 4'd0, 0, 2, 1, -1, -1, 2'b00, 4'd0, 32'hDEAD_BEEF, 1'b0);
        // ARREADY low 3 cycles
        run_read(32'h0000_2000, 4'd0, 3, 0, 1, -1, -1, 2'b00, 4'd0, 32'h1234_5678, 1'b0);
        // 4-beat burst, bubble before the third beat
        run_read(32'h0000_3000, 4'd3, 0, 1, 4, 2, -1, 2'b00, 4'd0, 32'd1, 1'b0);
        // SLVERR response, then a clean request clears err
        run_read(32'h0000_4000, 4'd0, 1, 0, 1, -1, 0, 2'b10, 4'd0, 32'hAAAA_0000, 1'b1);
        run_read(32'h0000_4004, 4'd0, 0, 0, 1, -1, -1, 2'b00, 4'd0, 32'hBBBB_0000, 1'b0);
        // early RLAST
        run_read(32'h0000_5000, 4'd1, 0, 0, 1, -1, -1, 2'b00, 4'd0, 32'hCCCC_0000, 1'b1);
        // RLAST two beats late
        run_read(32'h0000_6000, 4'd0, 0, 0, 3, -1, -1, 2'b00, 4'd0, 32'hDDDD_0000, 1'b1);
        // wrong RID on beat 1 of 2
        run_read(32'h0000_7000, 4'd1, 0, 0, 2, -1, 1, 2'b00, 4'd5, 32'hEEEE_0000, 1'b1);
        // RVALID outside DATA is ignored
        @(negedge clk);
        RVALID = 1'b1; RDATA = 32'hFFFF_FFFF; RLAST = 1'b1;
        @(negedge clk);
        check("rready_idle", RREADY, 0);
        @(negedge clk);
        check("no_beat_idle", rd_valid, 0);
        RVALID = 1'b0; RLAST = 1'b0;

        // reset mid-burst after beat 2 of 4 (beat 1 carries an error)
        @(negedge clk);
        req = 1'b1; req_addr = 32'h0000_8000; req_len = 4'd3; ARREADY = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ARREADY = 1'b0;
        for (int b = 0; b < 2; b++) begin
            RVALID = 1'b1; RDATA = 32'h0000_0100 + 32'(b); RID = 4'd0;
            RRESP = (b == 1) ? 2'b10 : 2'b00; RLAST = 1'b0;
            exp_q.push_back(32'h0000_0100 + 32'(b));
            @(negedge clk);
        end
        RVALID = 1'b0;
        req = 1'b0;
        check("pre_rst_err", err, 1);
        check("pre_rst_rready", RREADY, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_arvalid", ARVALID, 0);
        check("arst_rready", RREADY, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_state", dbg_state, 0);
        check("arst_rd_data", rd_data, 0);
        @(negedge clk);
        check("arst_hold_done", done, 0);
        rst = 1'b1;
        run_read(32'h0000_9000, 4'd1, 0, 1, 2, -1, -1, 2'b00, 4'd0, 32'h5555_0000, 1'b0);

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_err_q_drained", exp_err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
